// File: rtl/cache_dfp_arbiter.sv
// Two-way arbiter sharing one memory line port between the I- and D-caches.
// One transaction in flight; requests are latched on grant and held until m_resp.
module cache_dfp_arbiter #(
  parameter bit RR_EN = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  i_addr,
  input  logic         i_read,
  input  logic         i_write,
  input  logic [255:0] i_wdata,
  output logic [255:0] i_rdata,
  output logic         i_resp,
  input  logic [31:0]  d_addr,
  input  logic         d_read,
  input  logic         d_write,
  input  logic [255:0] d_wdata,
  output logic [255:0] d_rdata,
  output logic         d_resp,
  output logic [31:0]  m_addr,
  output logic         m_read,
  output logic         m_write,
  output logic [255:0] m_wdata,
  input  logic [255:0] m_rdata,
  input  logic         m_resp
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_BUSY_I = 2'd1,
    S_BUSY_D = 2'd2
  } state_t;

  state_t         r_state;
  state_t         w_next;
  logic           r_last;
  logic [31:0]    r_addr;
  logic           r_read;
  logic           r_write;
  logic [255:0]   r_wdata;
  logic           w_i_pend;
  logic           w_d_pend;
  logic           w_pick_d;
  logic           w_grant;

  assign w_i_pend = i_read | i_write;
  assign w_d_pend = d_read | d_write;

  // On a conflict, round-robin favours whoever was not served last
  always_comb begin
    if (w_i_pend && w_d_pend) begin
      w_pick_d = RR_EN ? ~r_last : 1'b1;
    end else begin
      w_pick_d = w_d_pend;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_i_pend || w_d_pend) begin
          w_next = w_pick_d ? S_BUSY_D : S_BUSY_I;
        end
      end
      S_BUSY_I, S_BUSY_D: begin
        if (m_resp) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign w_grant = (r_state == S_IDLE) && (w_next != S_IDLE);

  // Read+write together collapses to a write (writeback takes precedence)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last  <= 1'b0;
      r_addr  <= '0;
      r_read  <= 1'b0;
      r_write <= 1'b0;
      r_wdata <= '0;
    end else if (w_grant) begin
      r_last <= w_pick_d;
      if (w_pick_d) begin
        r_addr  <= d_addr;
        r_read  <= d_read & ~d_write;
        r_write <= d_write;
        r_wdata <= d_wdata;
      end else begin
        r_addr  <= i_addr;
        r_read  <= i_read & ~i_write;
        r_write <= i_write;
        r_wdata <= i_wdata;
      end
    end else if ((r_state != S_IDLE) && m_resp) begin
      r_read  <= 1'b0;
      r_write <= 1'b0;
    end
  end

  always_comb begin
    i_resp  = (r_state == S_BUSY_I) && m_resp;
    d_resp  = (r_state == S_BUSY_D) && m_resp;
    i_rdata = m_rdata;
    d_rdata = m_rdata;
    m_addr  = r_addr;
    m_read  = r_read;
    m_write = r_write;
    m_wdata = r_wdata;
  end

endmodule
